// File: rtl/frame_dump_sched.sv
// Frame dump scheduler: picks frames by decimation/limit, pulses the BMP writer's
// frame sync, holds the source through header setup, then streams one frame of pixels.
module frame_dump_sched #(
    parameter int unsigned SETUP_CYC = 20,
    parameter int unsigned DW        = 24,
    parameter int unsigned FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [15:0]       cfg_xres,
    input  logic [15:0]       cfg_yres,
    input  logic [FCNT_W-1:0] cfg_decim,
    input  logic [FCNT_W-1:0] cfg_max_frames,
    input  logic              s_sof,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_dat,
    output logic              s_ready,
    output logic              m_frame_sync_n,
    output logic              m_valid,
    output logic [DW-1:0]     m_dat,
    input  logic              m_ready,
    output logic [15:0]       m_xres,
    output logic [15:0]       m_yres,
    output logic [FCNT_W-1:0] frames_done,
    output logic              busy,
    output logic              done,
    output logic              err_short
);

    localparam int unsigned SC_W  = $clog2(SETUP_CYC + 1);
    localparam int unsigned PH_W  = FCNT_W + 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {IDLE, HUNT, SKIP, SYNC, SETUP, STREAM, DONE} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d, total, new_total;
    logic [SC_W-1:0]    setup_cnt;
    logic [FCNT_W-1:0]  fidx, max_q;
    logic [PH_W-1:0]    phase;
    logic               sof, res_ok, dump_sel;
    logic               hunt_eval, redo, lat, fin;

    assign sof       = s_valid & s_sof;
    assign res_ok    = (cfg_xres != 16'd0) && (cfg_yres != 16'd0);
    assign new_total = CNT_W'(cfg_xres) * CNT_W'(cfg_yres);
    assign phase     = PH_W'(fidx) % (PH_W'(cfg_decim) + PH_W'(1));
    assign dump_sel  = (phase == '0);

    // Next state, datapath handshake and per-cycle event strobes.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_dat     = '0;
        hunt_eval = 1'b0;
        redo      = 1'b0;
        lat       = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: if (enable) state_d = HUNT;
            HUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    hunt_eval = 1'b1;
                    s_ready   = !(sof && res_ok && dump_sel);
                end
            end
            SKIP: begin
                if (sof && (cnt != '0)) begin
                    redo = 1'b1;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        cnt_d = cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == total) state_d = enable ? HUNT : IDLE;
                    end
                end
            end
            SYNC:  state_d = SETUP;
            SETUP: if (setup_cnt == SC_W'(SETUP_CYC - 1)) state_d = STREAM;
            STREAM: begin
                if (sof && (cnt != '0)) begin
                    redo = 1'b1;
                end else begin
                    s_ready = m_ready;
                    m_valid = s_valid;
                    m_dat   = s_dat;
                    if (s_valid && m_ready) begin
                        cnt_d = cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == total) begin
                            fin = 1'b1;
                            if ((max_q != '0) && (frames_done + FCNT_W'(1) == max_q))
                                state_d = DONE;
                            else
                                state_d = enable ? HUNT : IDLE;
                        end
                    end
                end
            end
            DONE:    s_ready = 1'b1;
            default: state_d = IDLE;
        endcase

        // A premature SOF aborts the frame and is re-judged as a new frame, left unconsumed.
        if (redo) begin
            hunt_eval = 1'b1;
            state_d   = HUNT;
        end
        if (hunt_eval && sof && res_ok) begin
            lat   = 1'b1;
            cnt_d = (dump_sel || redo) ? '0 : CNT_W'(1);
            if (dump_sel)
                state_d = SYNC;
            else if (!redo && (new_total == CNT_W'(1)))
                state_d = HUNT;
            else
                state_d = SKIP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            total          <= '0;
            setup_cnt      <= '0;
            fidx           <= '0;
            max_q          <= '0;
            m_xres         <= '0;
            m_yres         <= '0;
            frames_done    <= '0;
            m_frame_sync_n <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_short      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            setup_cnt <= (state == SETUP) ? setup_cnt + SC_W'(1) : '0;
            if (lat) begin
                fidx   <= fidx + FCNT_W'(1);
                total  <= new_total;
                m_xres <= cfg_xres;
                m_yres <= cfg_yres;
                max_q  <= cfg_max_frames;
            end
            if (fin) frames_done <= frames_done + FCNT_W'(1);
            m_frame_sync_n <= (state_d != SYNC);
            busy           <= (state_d != IDLE) && (state_d != DONE);
            done           <= (state_d == DONE);
            err_short      <= redo;
        end
    end

endmodule
